serial2parallel_fifo: RTL and testbench
=======================================

Name: serial2parallel_fifo

Overview:
Parametrised serial-to-parallel converter. It assembles WIDTH-bit words from a gated serial bit stream and optionally realigns on a sync strobe. Completed words are buffered in a small FIFO and delivered over a valid/ready handshake. It sits between serial line front-ends and word-oriented datapath consumers, for consumers that can stall.

Parameters:
WIDTH, 8, word width in bits (≥2).
MSB_FIRST, 1, 1 = first received bit lands in dout_parallel[WIDTH-1]; 0 = first bit lands in dout_parallel[0].
FIFO_DEPTH, 2, output buffer entries (power of two, ≥2).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
din_serial  input  1  serial data bit
din_valid  input  1  din_serial is accepted this cycle
din_sync  input  1  qualified by din_valid; the accepted bit is bit 0 of a new word
dout_parallel  output  WIDTH  FIFO head word
dout_valid  output  1  FIFO non-empty
dout_ready  input  1  consumer accepts head word when dout_valid=1
bit_cnt  output  clog2(WIDTH+1)  bits accepted into current partial word
fifo_level  output  clog2(FIFO_DEPTH+1)  entries held
overflow  output  1  one-cycle pulse: completed word dropped, FIFO full

Behaviour:
- Reset (async, rst_n=0): bit_cnt=0, shift register=0, FIFO empty, fifo_level=0, dout_valid=0, dout_parallel=0, overflow=0. Reset mid-word or with FIFO contents discards everything.
- Bit acceptance: only on edges where din_valid=1. din_valid=0 holds the partial word and bit_cnt unchanged; gaps of any length are legal.
- Shift: MSB_FIRST=1 shifts left and inserts at LSB. MSB_FIRST=0 shifts right and inserts at MSB. Either way, after WIDTH bits the first bit occupies the position defined by MSB_FIRST.
- bit_cnt: increments per accepted bit. On the bit that makes the count WIDTH, the word completes and bit_cnt returns to 0 on the same edge; bit_cnt never shows WIDTH.
- Sync: din_valid=1 & din_sync=1 discards any partial word (no push, no error) and the bit is stored as bit 0, so bit_cnt becomes 1. If WIDTH-1 bits were pending, sync still discards them. din_sync with din_valid=0 is ignored.
- Push: the completed word is written to the FIFO on the completion edge. dout_valid rises on the next cycle, giving latency 1 clock from the last bit's edge to visibility.
- Pop: the head word is removed on an edge where dout_valid & dout_ready. dout_parallel is stable while dout_valid=1 & dout_ready=0.
- dout_parallel when empty: holds the last popped value. Verification must not check it while dout_valid=0.
- Simultaneous push & pop: level unchanged. This is legal when full, in which case the push succeeds and there is no overflow. When empty, the pushed word appears next cycle.
- Full, push without pop: the word is dropped and overflow=1 for exactly that following cycle. FIFO contents are untouched.
- fifo_level: +1 on push only, -1 on pop only, unchanged otherwise. It never exceeds FIFO_DEPTH.
- Pointers: wrap modulo FIFO_DEPTH, with full/empty derived from an extra pointer bit.

Optional Feature:
Macro S2P_PARITY_EN.
- Defined: each frame is WIDTH data bits plus one trailing even-parity bit.
  - bit_cnt counts to WIDTH+1.
  - The word is pushed only if the XOR of the data bits and the parity bit is 0.
  - On mismatch the word is dropped and output parity_err (1 bit) pulses for one cycle. Overflow is not checked for dropped words.
  - Sync behaviour is unchanged, and sync may also abort a pending parity bit.
- Undefined: frames are WIDTH bits, port parity_err is absent, and no parity logic is built.

Test Plan:
- WIDTH=8, MSB_FIRST=1, dout_ready=1, din_valid=1, bits 1,0,1,1,0,0,1,0 -> dout_parallel=8'hB2 with dout_valid=1 one cycle after the 8th bit, then dout_valid=0.
- MSB_FIRST=0, same bits -> 8'h4D. Insert 3 din_valid=0 gaps mid-word -> same result, and bit_cnt holds through the gaps.
- Send 5 bits, then din_sync with bit 1 plus 7 bits 0 -> single word 8'h80 (MSB_FIRST=1); the partial word is never output and no overflow occurs.
- FIFO_DEPTH=2, dout_ready=0, send words 8'h11, 8'h22, 8'h33 -> fifo_level=2, overflow pulses once after 8'h33; release ready -> 8'h11 then 8'h22 are output, and 8'h33 is never output.
- Full FIFO, complete a word on the same edge as a pop -> no overflow, fifo_level stays 2, and output order is preserved.
- Assert rst_n=0 mid-word with the FIFO holding 1 entry -> outputs zero immediately (async). After release, a fresh 8-bit word converts correctly. With S2P_PARITY_EN, data 8'hB2 with parity bit 0 -> pushed; the same data with parity bit 1 -> parity_err pulse and no push.

Source files
------------

// File: rtl/serial2parallel_fifo.sv
// serial2parallel_fifo: gated serial-to-parallel converter with sync realignment
// and a small valid/ready output FIFO.
// Optional build macro S2P_PARITY_EN adds a trailing even-parity bit per frame
// and the parity_err output.
module serial2parallel_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MSB_FIRST  = 1,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              din_serial,
  input  logic                              din_valid,
  input  logic                              din_sync,
  output logic [WIDTH-1:0]                  dout_parallel,
  output logic                              dout_valid,
  input  logic                              dout_ready,
  output logic [$clog2(WIDTH+1)-1:0]        bit_cnt,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              overflow
`ifdef S2P_PARITY_EN
  ,
  output logic                              parity_err
`endif
);

  localparam int unsigned CW = $clog2(WIDTH+1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
`ifdef S2P_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] shift_in;
  logic [WIDTH-1:0] word;
  logic             done;
  logic             good;
  logic             push;

  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             ovf_q, ovf_d;
  logic             pop, full, empty, wr_en;
`ifdef S2P_PARITY_EN
  logic             perr_q, perr_d;
`endif

  // Shift direction: MSB-first inserts at LSB, LSB-first inserts at MSB.
  always_comb begin
    shift_in = '0;
    if (MSB_FIRST != 0) shift_in = {shift_q[WIDTH-2:0], din_serial};
    else                shift_in = {din_serial, shift_q[WIDTH-1:1]};
  end

  // Word assembly: bit counting, sync realignment and frame completion.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    done    = 1'b0;
    word    = shift_in;
    good    = 1'b1;
    if (din_valid) begin
      if (din_sync) begin
        // Sync drops the partial word and restarts with this bit as bit 0.
        cnt_d = CW'(1);
        if (MSB_FIRST != 0) shift_d = {{(WIDTH-1){1'b0}}, din_serial};
        else                shift_d = {din_serial, {(WIDTH-1){1'b0}}};
      end else if (cnt_q == LAST) begin
        cnt_d = '0;
        done  = 1'b1;
`ifdef S2P_PARITY_EN
        // Final bit is parity: data is already complete in the shifter.
        word  = shift_q;
        good  = ~^{shift_q, din_serial};
`else
        shift_d = shift_in;
`endif
      end else begin
        cnt_d   = cnt_q + 1'b1;
        shift_d = shift_in;
      end
    end
  end

  assign push = done & good;

  // FIFO control: pointers carry an extra wrap bit to separate full from empty.
  always_comb begin
    empty = (wr_q == rd_q);
    full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop   = ~empty & dout_ready;
    wr_en = push & (~full | pop);
    ovf_d = push & full & ~pop;
    wr_d  = wr_q + PW'(wr_en);
    rd_d  = rd_q + PW'(pop);
    mem_d = mem_q;
    if (wr_en) mem_d[wr_q[AW-1:0]] = word;
    hold_d = hold_q;
    if (pop) hold_d = mem_q[rd_q[AW-1:0]];
`ifdef S2P_PARITY_EN
    perr_d = done & ~good;
`endif
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      hold_q  <= '0;
      ovf_q   <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef S2P_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
      mem_q   <= mem_d;
`ifdef S2P_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Output decode; an empty FIFO shows the last word popped.
  always_comb begin
    dout_valid    = ~empty;
    dout_parallel = empty ? hold_q : mem_q[rd_q[AW-1:0]];
    fifo_level    = wr_q - rd_q;
    bit_cnt       = cnt_q;
    overflow      = ovf_q;
`ifdef S2P_PARITY_EN
    parity_err    = perr_q;
`endif
  end

endmodule

// File: tb/tb_serial2parallel_fifo.sv
// Bench for serial2parallel_fifo: two instances (MSB-first and LSB-first) share
// the stimulus; a queue-level reference model is compared every cycle, plus
// literal expectations from hand-worked examples.
module tb_serial2parallel_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       din_serial = 1'b0;
  logic       din_valid = 1'b0;
  logic       din_sync = 1'b0;
  logic       dout_ready = 1'b0;

  logic [7:0] dp0, dp1;
  logic       dv0, dv1, ov0, ov1;
  logic [3:0] bc0, bc1;
  logic [1:0] fl0, fl1;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  serial2parallel_fifo #(.WIDTH(8), .MSB_FIRST(1), .FIFO_DEPTH(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .din_serial(din_serial), .din_valid(din_valid),
    .din_sync(din_sync), .dout_parallel(dp0), .dout_valid(dv0),
    .dout_ready(dout_ready), .bit_cnt(bc0), .fifo_level(fl0), .overflow(ov0)
  );

  serial2parallel_fifo #(.WIDTH(8), .MSB_FIRST(0), .FIFO_DEPTH(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .din_serial(din_serial), .din_valid(din_valid),
    .din_sync(din_sync), .dout_parallel(dp1), .dout_valid(dv1),
    .dout_ready(dout_ready), .bit_cnt(bc1), .fifo_level(fl1), .overflow(ov1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: list of received bits, word built only at completion,
  // FIFO as an array with the head at index 0. Index 0 = MSB-first instance.
  int         m_n   [2];
  bit         m_b   [2][8];
  logic [7:0] m_f   [2][2];
  int         m_sz  [2];
  bit         m_ovf [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_n[k] = 0; m_sz[k] = 0; m_ovf[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit         push;
        bit         popv;
        logic [7:0] w;
        push = 1'b0;
        w    = '0;
        popv = dout_ready && (m_sz[k] > 0);
        if (din_valid) begin
          if (din_sync) m_n[k] = 0;
          m_b[k][m_n[k]] = din_serial;
          m_n[k]++;
          if (m_n[k] == 8) begin
            for (int i = 0; i < 8; i++) w[(k == 0) ? 7 - i : i] = m_b[k][i];
            push   = 1'b1;
            m_n[k] = 0;
          end
        end
        m_ovf[k] = push && (m_sz[k] == 2) && !popv;
        if (popv) begin
          m_f[k][0] = m_f[k][1];
          m_sz[k]--;
        end
        if (push && m_sz[k] < 2) begin
          m_f[k][m_sz[k]] = w;
          m_sz[k]++;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("bit_cnt0", bc0, m_n[0]);
      chk("bit_cnt1", bc1, m_n[1]);
      chk("level0", fl0, m_sz[0]);
      chk("level1", fl1, m_sz[1]);
      chk("valid0", dv0, m_sz[0] > 0);
      chk("valid1", dv1, m_sz[1] > 0);
      chk("ovf0", ov0, m_ovf[0]);
      chk("ovf1", ov1, m_ovf[1]);
      if (m_sz[0] > 0) chk("head0", dp0, m_f[0][0]);
      if (m_sz[1] > 0) chk("head1", dp1, m_f[1][0]);
    end
  end

  // One clock: drive inputs, take the edge, return 2 time units after it.
  task automatic cyc(input logic v, input logic d, input logic s, input logic r);
    din_valid = v; din_serial = d; din_sync = s; dout_ready = r;
    @(posedge clk); #2;
  endtask

  // Serialise a byte MSB-first; r_last is dout_ready on the final bit's edge.
  task automatic send(input logic [7:0] w, input logic r, input logic r_last);
    for (int i = 7; i >= 0; i--) cyc(1'b1, w[i], 1'b0, (i == 0) ? r_last : r);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_bc"}, {bc1, bc0}, 0);
    chk({tag, "_lvl"}, {fl1, fl0}, 0);
    chk({tag, "_vld"}, {dv1, dv0}, 0);
    chk({tag, "_dout"}, {dp1, dp0}, 0);
    chk({tag, "_ovf"}, {ov1, ov0}, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    @(posedge clk); #2;
    check_zero("reset");
    cmp_en = 1'b1;

    // Basic conversion with consumer always ready.
    send(8'hB2, 1'b1, 1'b1);
    chk("basic_vld", dv0, 1);
    chk("basic_msb", dp0, 8'hB2);
    chk("basic_lsb", dp1, 8'h4D);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("basic_drain", {dv1, dv0}, 0);

    // Same word with a three-cycle gap after the fourth bit.
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    for (int g = 0; g < 3; g++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("gap_hold", {bc1, bc0}, {4'd4, 4'd4});
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("gap_msb", dp0, 8'hB2);
    chk("gap_lsb", dp1, 8'h4D);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Sync after 5 pending bits: only the realigned word emerges.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("sync_bc", bc0, 1);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("sync_lvl", fl0, 1);
    chk("sync_ovf", ov0, 0);
    chk("sync_msb", dp0, 8'h80);
    chk("sync_lsb", dp1, 8'h01);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("sync_drain", dv0, 0);

    // Overflow: third word into a full FIFO is dropped.
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    chk("ovf_pre", ov0, 0);
    send(8'h33, 1'b0, 1'b0);
    chk("ovf_lvl", fl0, 2);
    chk("ovf_pulse", ov0, 1);
    chk("ovf_head", dp0, 8'h11);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_clear", ov0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_pop1", dp0, 8'h22);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_empty", dv0, 0);

    // Completion on the same edge as a pop while full.
    send(8'hA1, 1'b0, 1'b0);
    send(8'hA2, 1'b0, 1'b0);
    send(8'hA3, 1'b0, 1'b1);
    chk("pp_lvl", fl0, 2);
    chk("pp_ovf", ov0, 0);
    chk("pp_head", dp0, 8'hA2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("pp_next", dp0, 8'hA3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("pp_empty", dv0, 0);

    // Asynchronous reset mid-word with one entry held.
    send(8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    din_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("async");
    #5 rst_n = 1'b1;
    @(posedge clk); #2;
    send(8'hB2, 1'b0, 1'b0);
    chk("post_msb", dp0, 8'hB2);
    chk("post_lsb", dp1, 8'h4D);
    chk("post_lvl", fl0, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
